cp0_ctrl_unit: RTL and testbench

Parametrised CP0 system-control block for the 5-stage MIPS pipeline. Sits at the commit (WB-boundary) point and holds Status, Cause, EPC, BadVAddr, Count and Compare. Exceptions arrive already decoded from upstream stages. The block arbitrates interrupts against committed exceptions and ERET, and issues a single-cycle pipeline flush with its redirect target.

---
 rtl/cp0_pkg.sv | 36 +++
 rtl/cp0_ctrl_unit_if.sv | 39 +++
 rtl/cp0_timer.sv | 54 +++++
 rtl/cp0_ctrl_unit.sv | 135 +++++++++++++
 tb/tb_cp0_ctrl_unit.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, the exception
// vector and the bit positions of the Status and Cause fields.
package cp0_pkg;

  // CP0 register numbers (sel is always 0)
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  // Status bit positions
  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_BEV   = 22;

  // Cause bit positions
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

endpackage

// File: rtl/cp0_ctrl_unit_if.sv
// Commit-side bus between the pipeline and the CP0 block.
// Handshake: there is no backpressure. cmt_valid qualifies every cmt_* and
// mtc0_* field in the same cycle; flush is a one-cycle pulse and flush_pc is
// meaningful only while flush = 1. mfc0_rdata, int_pending and epc_q are
// always valid (combinational / register state).
// master: pipeline side, slave: CP0 side.
interface cp0_ctrl_unit_if #(
  parameter int HW_INT_NUM = 6
);
  logic [HW_INT_NUM-1:0] hw_int;
  logic                  cmt_valid;
  logic [31:0]           cmt_pc;
  logic                  cmt_bd;
  logic                  cmt_exc;
  logic [4:0]            cmt_excode;
  logic [31:0]           cmt_badv;
  logic                  cmt_eret;
  logic                  mtc0_en;
  logic [4:0]            mtc0_addr;
  logic [31:0]           mtc0_wdata;
  logic [4:0]            mfc0_addr;
  logic [31:0]           mfc0_rdata;
  logic                  int_pending;
  logic                  flush;
  logic [31:0]           flush_pc;
  logic [31:0]           epc_q;

  modport master (
    output hw_int, cmt_valid, cmt_pc, cmt_bd, cmt_exc, cmt_excode, cmt_badv,
           cmt_eret, mtc0_en, mtc0_addr, mtc0_wdata, mfc0_addr,
    input  mfc0_rdata, int_pending, flush, flush_pc, epc_q
  );

  modport slave (
    input  hw_int, cmt_valid, cmt_pc, cmt_bd, cmt_exc, cmt_excode, cmt_badv,
           cmt_eret, mtc0_en, mtc0_addr, mtc0_wdata, mfc0_addr,
    output mfc0_rdata, int_pending, flush, flush_pc, epc_q
  );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer. Count advances once every COUNT_DIV clocks; a match
// on an increment cycle sets the sticky timer interrupt, which only a write
// to Compare clears (the clear wins over a coincident set).
// Ports: clk, resetn (sync, active-low), count_we/compare_we write strobes,
// wdata, count/compare register values, timer_irq (TI).
module cp0_timer #(
  parameter int          COUNT_DIV   = 2,
  parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_irq
);
  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] phase;
  logic          tick;

  assign tick = (phase == PH_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count     <= '0;
      phase     <= '0;
      compare   <= COMPARE_RST;
      timer_irq <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        phase <= '0;
      end else if (tick) begin
        count <= count + 32'd1;
        phase <= '0;
      end else begin
        phase <= phase + PW'(1);
      end

      if (compare_we)
        compare <= wdata;

      // A Count write suppresses the increment, so no match can fire then.
      if (compare_we)
        timer_irq <= 1'b0;
      else if (tick && !count_we && (count == compare))
        timer_irq <= 1'b1;
    end
  end
endmodule

// File: rtl/cp0_ctrl_unit.sv
// CP0 system-control block at the commit point. Holds Status, Cause, EPC,
// BadVAddr and (via cp0_timer) Count/Compare; arbitrates interrupt >
// exception > ERET > MTC0 for the committing instruction and raises a
// one-cycle flush with its redirect target.
// Ports: clk, resetn (sync, active-low), bus (cp0_ctrl_unit_if.slave).
module cp0_ctrl_unit
  import cp0_pkg::*;
#(
  parameter int          HW_INT_NUM  = 6,
  parameter int          COUNT_DIV   = 2,
  parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               resetn,
  cp0_ctrl_unit_if.slave     bus
);
  logic [7:0]  im;
  logic        exl, ie;
  logic        bd;
  logic [4:0]  exccode;
  logic [1:0]  ip_soft;
  logic [5:0]  hw_q;
  logic [31:0] epc, badvaddr;
  logic [31:0] count, compare;
  logic        ti;

  logic [5:0]  hw_ext;
  logic [5:0]  ip_hard;
  logic [7:0]  ip;
  logic        take_int, take_exc, take_eret, do_mtc0;
  logic        count_we, compare_we;
  logic [31:0] status_rd, cause_rd;

  // Unused interrupt lines read as 0; with 6 lines the top one shares IP7.
  always_comb begin
    hw_ext = '0;
    hw_ext[HW_INT_NUM-1:0] = bus.hw_int;
  end

  assign ip_hard = {hw_q[5] | ti, hw_q[4:0]};
  assign ip      = {ip_hard, ip_soft};

  assign bus.int_pending = ie & ~exl & (|(ip & im));

  assign take_int  = bus.cmt_valid & bus.int_pending;
  assign take_exc  = bus.cmt_valid & ~bus.int_pending & bus.cmt_exc;
  assign take_eret = bus.cmt_valid & ~bus.int_pending & ~bus.cmt_exc & bus.cmt_eret;
  assign do_mtc0   = bus.cmt_valid & bus.mtc0_en & ~take_int & ~take_exc & ~take_eret;

  assign count_we   = do_mtc0 & (bus.mtc0_addr == CP0_COUNT);
  assign compare_we = do_mtc0 & (bus.mtc0_addr == CP0_COMPARE);

  assign bus.flush    = resetn & (take_int | take_exc | take_eret);
  assign bus.flush_pc = take_eret ? epc : EXC_VECTOR;
  assign bus.epc_q    = epc;

  cp0_timer #(
    .COUNT_DIV   (COUNT_DIV),
    .COMPARE_RST (COMPARE_RST)
  ) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .count_we   (count_we),
    .compare_we (compare_we),
    .wdata      (bus.mtc0_wdata),
    .count      (count),
    .compare    (compare),
    .timer_irq  (ti)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      exccode  <= '0;
      ip_soft  <= '0;
      hw_q     <= '0;
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      hw_q <= hw_ext;
      if (take_int || take_exc) begin
        // Nested exceptions keep the original return point.
        if (!exl) begin
          epc <= bus.cmt_bd ? bus.cmt_pc - 32'd4 : bus.cmt_pc;
          bd  <= bus.cmt_bd;
        end
        exl     <= 1'b1;
        exccode <= take_int ? EXC_INT : bus.cmt_excode;
        if (take_exc && (bus.cmt_excode == EXC_ADEL || bus.cmt_excode == EXC_ADES))
          badvaddr <= bus.cmt_badv;
      end else if (take_eret) begin
        exl <= 1'b0;
      end else if (do_mtc0) begin
        case (bus.mtc0_addr)
          CP0_STATUS: begin
            im  <= bus.mtc0_wdata[ST_IM_LO +: 8];
            exl <= bus.mtc0_wdata[ST_EXL];
            ie  <= bus.mtc0_wdata[ST_IE];
          end
          CP0_CAUSE: ip_soft <= bus.mtc0_wdata[CA_IP_LO +: 2];
          CP0_EPC:   epc     <= bus.mtc0_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    status_rd = '0;
    status_rd[ST_BEV]        = 1'b1;
    status_rd[ST_IM_LO +: 8] = im;
    status_rd[ST_EXL]        = exl;
    status_rd[ST_IE]         = ie;
    cause_rd = '0;
    cause_rd[CA_BD]          = bd;
    cause_rd[CA_TI]          = ti;
    cause_rd[CA_IP_LO +: 8]  = ip;
    cause_rd[CA_EXC_LO +: 5] = exccode;
  end

  always_comb begin
    case (bus.mfc0_addr)
      CP0_BADVADDR: bus.mfc0_rdata = badvaddr;
      CP0_COUNT:    bus.mfc0_rdata = count;
      CP0_COMPARE:  bus.mfc0_rdata = compare;
      CP0_STATUS:   bus.mfc0_rdata = status_rd;
      CP0_CAUSE:    bus.mfc0_rdata = cause_rd;
      CP0_EPC:      bus.mfc0_rdata = epc;
      default:      bus.mfc0_rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_cp0_ctrl_unit.sv
module tb_cp0_ctrl_unit;
  import cp0_pkg::*;

  logic clk;
  logic resetn;

  cp0_ctrl_unit_if #(.HW_INT_NUM(6)) bus ();

  cp0_ctrl_unit #(
    .HW_INT_NUM  (6),
    .COUNT_DIV   (2),
    .COMPARE_RST (32'hFFFF_FFFF)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];      // expected read values
  string       name_q[$];
  logic [1:0]  kind_q[$];     // 0: mfc0_rdata, 1: int_pending, 2: epc_q
  logic [31:0] fl_q[$];       // expected flush_pc
  string       fl_name_q[$];
  logic        rd_req;
  logic        fl_req;
  int          n_tests;
  int          n_fail;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [31:0] exp_v, act_v;
    logic [1:0]  k;
    string       nm;
    if (fl_req) begin
      exp_v = fl_q.pop_front();
      nm    = fl_name_q.pop_front();
      n_tests++;
      if (bus.flush !== 1'b1 || bus.flush_pc !== exp_v) begin
        n_fail++;
        $display("FAIL %s: flush=%b flush_pc=%h, required flush=1 flush_pc=%h",
                 nm, bus.flush, bus.flush_pc, exp_v);
      end
    end else if (bus.flush !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_flush: flush=%b at %0t, required 0", bus.flush, $time);
    end
    if (rd_req) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      k     = kind_q.pop_front();
      case (k)
        2'd1:    act_v = {31'd0, bus.int_pending};
        2'd2:    act_v = bus.epc_q;
        default: act_v = bus.mfc0_rdata;
      endcase
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s: got %h, required %h", nm, act_v, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_cmt();
    bus.cmt_valid  = 1'b0;
    bus.cmt_pc     = '0;
    bus.cmt_bd     = 1'b0;
    bus.cmt_exc    = 1'b0;
    bus.cmt_excode = '0;
    bus.cmt_badv   = '0;
    bus.cmt_eret   = 1'b0;
    bus.mtc0_en    = 1'b0;
    bus.mtc0_addr  = '0;
    bus.mtc0_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_cmt();
    rd_req = 1'b0;
    fl_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Queue a read check for the coming cycle without consuming it.
  task automatic arm_read(input logic [1:0] kind, input logic [4:0] addr,
                          input logic [31:0] exp_v, input string nm);
    bus.mfc0_addr = addr;
    rd_req = 1'b1;
    exp_q.push_back(exp_v);
    name_q.push_back(nm);
    kind_q.push_back(kind);
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp_v, input string nm);
    arm_read(2'd0, addr, exp_v, nm);
    step();
  endtask

  task automatic chk(input logic [1:0] kind, input logic [31:0] exp_v, input string nm);
    arm_read(kind, 5'd0, exp_v, nm);
    step();
  endtask

  task automatic expect_flush(input logic [31:0] pc, input string nm);
    fl_req = 1'b1;
    fl_q.push_back(pc);
    fl_name_q.push_back(nm);
  endtask

  task automatic commit(input logic [31:0] pc, input logic bd, input logic exc,
                        input logic [4:0] code, input logic [31:0] badv,
                        input logic eret, input logic men, input logic [4:0] maddr,
                        input logic [31:0] wdata);
    bus.cmt_valid  = 1'b1;
    bus.cmt_pc     = pc;
    bus.cmt_bd     = bd;
    bus.cmt_exc    = exc;
    bus.cmt_excode = code;
    bus.cmt_badv   = badv;
    bus.cmt_eret   = eret;
    bus.mtc0_en    = men;
    bus.mtc0_addr  = maddr;
    bus.mtc0_wdata = wdata;
    step();
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] wdata);
    commit(32'h8000_0000, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, addr, wdata);
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    // A committing exception during reset must not flush.
    for (int i = 0; i < n; i++) begin
      bus.cmt_valid  = 1'b1;
      bus.cmt_exc    = 1'b1;
      bus.cmt_excode = EXC_SYS;
      @(posedge clk);
      #1;
    end
    resetn = 1'b1;
    clear_cmt();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    rd_req  = 1'b0;
    fl_req  = 1'b0;
    bus.hw_int    = '0;
    bus.mfc0_addr = '0;
    clear_cmt();
    do_reset(4);

    // Reset state
    rd(CP0_STATUS,   32'h0040_0000, "rst_status");
    rd(CP0_COMPARE,  32'hFFFF_FFFF, "rst_compare");
    rd(CP0_CAUSE,    32'h0000_0000, "rst_cause");
    rd(CP0_EPC,      32'h0000_0000, "rst_epc");
    rd(CP0_BADVADDR, 32'h0000_0000, "rst_badv");
    rd(5'd15,        32'h0000_0000, "unimpl_reg");
    chk(2'd1,        32'd0,         "rst_int_pending");

    // Timer interrupt
    mtc0(CP0_COMPARE, 32'd10);
    mtc0(CP0_COUNT,   32'd0);
    mtc0(CP0_STATUS,  32'hFFFF_8001);
    rd(CP0_STATUS, 32'h0040_8001, "status_write_mask");
    mtc0(CP0_BADVADDR, 32'h5555_5555);
    rd(CP0_BADVADDR, 32'h0000_0000, "badv_write_ignored");
    idle(30);
    chk(2'd1, 32'd1, "timer_int_pending");
    rd(CP0_CAUSE, 32'h4000_8000, "timer_cause_ti");

    expect_flush(EXC_VECTOR, "timer_int_flush");
    commit(32'h8000_0100, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    rd(CP0_EPC,    32'h8000_0100, "int_epc");
    rd(CP0_CAUSE,  32'h4000_8000, "int_cause");
    rd(CP0_STATUS, 32'h0040_8003, "int_status_exl");
    chk(2'd2, 32'h8000_0100, "int_epc_q");
    chk(2'd1, 32'd0, "exl_masks_int");

    // Clear TI, return, then address-error exception in a delay slot
    mtc0(CP0_COMPARE, 32'hFFFF_0000);
    rd(CP0_CAUSE, 32'h0000_0000, "compare_clears_ti");
    expect_flush(32'h8000_0100, "eret1_flush");
    commit(32'h8000_0180, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    rd(CP0_STATUS, 32'h0040_8001, "eret1_status");
    expect_flush(EXC_VECTOR, "adel_flush");
    commit(32'h8000_0204, 1'b1, 1'b1, EXC_ADEL, 32'h0000_1001, 1'b0, 1'b0, 5'd0, 32'd0);
    rd(CP0_EPC,      32'h8000_0200, "adel_epc_bd");
    rd(CP0_CAUSE,    32'h8000_0010, "adel_cause");
    rd(CP0_BADVADDR, 32'h0000_1001, "adel_badv");
    expect_flush(EXC_VECTOR, "nested_flush");
    commit(32'h8000_0400, 1'b0, 1'b1, EXC_SYS, 32'h0000_DEAD, 1'b0, 1'b0, 5'd0, 32'd0);
    rd(CP0_EPC,      32'h8000_0200, "nested_epc_held");
    rd(CP0_CAUSE,    32'h8000_0020, "nested_cause");
    rd(CP0_BADVADDR, 32'h0000_1001, "nested_badv_held");

    // Interrupt beats exception and MTC0 in the same commit
    mtc0(CP0_STATUS, 32'h0000_0401);
    rd(CP0_STATUS, 32'h0040_0401, "status_im2");
    bus.hw_int = 6'b00_0001;
    idle(2);
    chk(2'd1, 32'd1, "hw_int_pending");
    rd(CP0_CAUSE, 32'h8000_0420, "hw_cause_ip2");
    expect_flush(EXC_VECTOR, "prio_flush");
    commit(32'h8000_0500, 1'b0, 1'b1, EXC_OV, 32'd0, 1'b0, 1'b1, CP0_EPC, 32'h1234_5678);
    rd(CP0_EPC,    32'h8000_0500, "prio_epc_mtc0_dropped");
    rd(CP0_CAUSE,  32'h0000_0400, "prio_cause_int");
    rd(CP0_STATUS, 32'h0040_0403, "prio_status");

    // MTC0 EPC: same-cycle read sees old value, next cycle sees new
    arm_read(2'd0, CP0_EPC, 32'h8000_0500, "raw_same_cycle");
    mtc0(CP0_EPC, 32'h8000_0300);
    rd(CP0_EPC, 32'h8000_0300, "raw_next_cycle");
    expect_flush(32'h8000_0300, "eret2_flush");
    commit(32'h8000_0600, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    rd(CP0_STATUS, 32'h0040_0401, "eret2_status");
    chk(2'd1, 32'd1, "eret2_int_pending");
    expect_flush(EXC_VECTOR, "hw_int_taken_flush");
    commit(32'h8000_0304, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    rd(CP0_EPC,   32'h8000_0304, "hw_int_epc");
    rd(CP0_CAUSE, 32'h0000_0400, "hw_int_cause");
    bus.hw_int = '0;

    // Count wrap
    mtc0(CP0_COUNT, 32'hFFFF_FFFF);
    rd(CP0_COUNT, 32'hFFFF_FFFF, "count_max_a");
    rd(CP0_COUNT, 32'hFFFF_FFFF, "count_max_b");
    rd(CP0_COUNT, 32'h0000_0000, "count_wrap");

    // Compare write coinciding with a match: clear wins
    mtc0(CP0_COMPARE, 32'd5);
    mtc0(CP0_COUNT,   32'd5);
    idle(1);
    mtc0(CP0_COMPARE, 32'd5);
    rd(CP0_CAUSE, 32'h0000_0000, "clear_wins_over_match");
    mtc0(CP0_COUNT, 32'd4);
    idle(6);
    rd(CP0_CAUSE, 32'h4000_8000, "match_sets_ti");

    // Reset mid-operation
    do_reset(2);
    rd(CP0_STATUS,  32'h0040_0000, "rerst_status");
    rd(CP0_COMPARE, 32'hFFFF_FFFF, "rerst_compare");
    rd(CP0_CAUSE,   32'h0000_0000, "rerst_cause");
    rd(CP0_EPC,     32'h0000_0000, "rerst_epc");

    idle(2);
    n_tests++;
    if (exp_q.size() != 0 || fl_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d reads and %0d flushes left, required 0",
               exp_q.size(), fl_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
